// File: rtl/adc_current_cond_if.sv
// Signal bundle between the ADC controller / control loop and adc_current_cond.
// master drives requests and samples; slave is the conditioning block.
interface adc_current_cond_if #(
    parameter int N_CH = 3,
    parameter int DW   = 16
);
    logic                 recal;
    logic                 start_conv_run;
    logic                 start_conv;
    logic                 adc_done;
    logic [N_CH*DW-1:0]   adc_data;
    logic [N_CH*DW-1:0]   i_out;
    logic                 i_valid;
    logic [N_CH-1:0]      sat_flag;
    logic [N_CH*DW-1:0]   bias;
    logic                 calib_done;
    logic                 oc_trip;

    modport master (
        output recal, start_conv_run, adc_done, adc_data,
        input  start_conv, i_out, i_valid, sat_flag, bias, calib_done, oc_trip
    );

    modport slave (
        input  recal, start_conv_run, adc_done, adc_data,
        output start_conv, i_out, i_valid, sat_flag, bias, calib_done, oc_trip
    );
endinterface

// File: rtl/adc_current_cond.sv
// Phase-current conditioning: bias calibration by averaging, then offset/gain/saturate.
// Optional overcurrent latch enabled by defining OVERCURRENT_TRIP_EN.
module adc_current_cond #(
    parameter int N_CH        = 3,
    parameter int DW          = 16,
    parameter int LOG2_NSAMP  = 12,
    parameter int GAIN        = 58514,
    parameter int GAIN_FRAC   = 13,
    parameter int CONV_PERIOD = 1500,
    parameter int OUT_MAX     = 32767
`ifdef OVERCURRENT_TRIP_EN
    , parameter int TRIP_LEVEL = 26214
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    adc_current_cond_if.slave bus
);
    localparam int AW  = DW + LOG2_NSAMP;
    localparam int CW  = LOG2_NSAMP + 1;
    localparam int PCW = $clog2(CONV_PERIOD + 2);
    localparam int GW  = $clog2(GAIN + 1) + 1;
    localparam int PW  = DW + 1 + GW;
    localparam logic signed [PW-1:0] GAIN_S = PW'(GAIN);
    localparam logic signed [PW-1:0] LIM    = PW'(OUT_MAX);

    typedef enum logic [1:0] {CAL_CLR, CAL_ACC, CAL_FIN, RUN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   samp_cnt_reg;
    logic [PCW-1:0]  per_cnt_reg;
    logic            start_conv_reg;
    logic            i_valid_reg;
    logic            calib_done_reg;
    logic            accept_cal, accept_run;

    // recal always wins over a coincident sample
    assign accept_cal = (state_reg == CAL_ACC) && bus.adc_done && !bus.recal;
    assign accept_run = (state_reg == RUN) && bus.adc_done && !bus.recal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= CAL_CLR;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CAL_CLR: state_next = CAL_ACC;
            CAL_ACC: if (accept_cal && samp_cnt_reg == CW'((1 << LOG2_NSAMP) - 1))
                         state_next = CAL_FIN;
            CAL_FIN: state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CAL_CLR;
        endcase
        if (bus.recal) state_next = CAL_CLR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_reg   <= '0;
            per_cnt_reg    <= '0;
            start_conv_reg <= 1'b0;
            i_valid_reg    <= 1'b0;
            calib_done_reg <= 1'b0;
        end else begin
            start_conv_reg <= 1'b0;
            i_valid_reg    <= accept_run;
            calib_done_reg <= (state_next == RUN);
            case (state_reg)
                CAL_CLR: begin
                    samp_cnt_reg <= '0;
                    per_cnt_reg  <= '0;
                end
                CAL_ACC: begin
                    if (per_cnt_reg == PCW'(CONV_PERIOD)) begin
                        per_cnt_reg    <= '0;
                        start_conv_reg <= !bus.recal;
                    end else begin
                        per_cnt_reg <= per_cnt_reg + 1'b1;
                    end
                    if (accept_cal) samp_cnt_reg <= samp_cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // In RUN the PWM trigger bypasses the register so its phase is not shifted
    assign bus.start_conv = (state_reg == RUN) ? bus.start_conv_run : start_conv_reg;
    assign bus.i_valid    = i_valid_reg;
    assign bus.calib_done = calib_done_reg;

`ifdef OVERCURRENT_TRIP_EN
    logic [N_CH-1:0] trip_hit;
    logic            oc_trip_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [DW-1:0] sample;
            logic signed [AW-1:0] acc_reg;
            logic signed [DW-1:0] bias_reg, i_out_reg;
            logic                 sat_reg;
            logic signed [DW:0]   diff;
            logic signed [PW-1:0] diff_ext, prod, scaled;
            logic signed [DW-1:0] clamped;
            logic                 clip;

            assign sample   = bus.adc_data[gi*DW +: DW];
            assign diff     = {sample[DW-1], sample} - {bias_reg[DW-1], bias_reg};
            assign diff_ext = {{(PW-DW-1){diff[DW]}}, diff};
            assign prod     = diff_ext * GAIN_S;
            assign scaled   = prod >>> GAIN_FRAC;

            always_comb begin
                clamped = scaled[DW-1:0];
                clip    = 1'b0;
                if (scaled > LIM) begin
                    clamped = DW'(OUT_MAX);
                    clip    = 1'b1;
                end else if (scaled < -LIM) begin
                    clamped = DW'(-OUT_MAX);
                    clip    = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg   <= '0;
                    bias_reg  <= '0;
                    i_out_reg <= '0;
                    sat_reg   <= 1'b0;
                end else begin
                    if (state_reg == CAL_CLR)
                        acc_reg <= '0;
                    else if (accept_cal)
                        acc_reg <= acc_reg + {{LOG2_NSAMP{sample[DW-1]}}, sample};
                    if (state_reg == CAL_FIN)
                        bias_reg <= DW'(acc_reg >>> LOG2_NSAMP);
                    if (accept_run) begin
                        i_out_reg <= clamped;
                        sat_reg   <= clip;
                    end
                end
            end

            assign bus.i_out[gi*DW +: DW] = i_out_reg;
            assign bus.bias[gi*DW +: DW]  = bias_reg;
            assign bus.sat_flag[gi]       = sat_reg;

`ifdef OVERCURRENT_TRIP_EN
            logic signed [DW:0] mag;
            assign mag          = clamped[DW-1] ? -{clamped[DW-1], clamped} : {clamped[DW-1], clamped};
            assign trip_hit[gi] = (mag >= (DW+1)'(TRIP_LEVEL));
`endif
        end
    endgenerate

`ifdef OVERCURRENT_TRIP_EN
    // Sticky until recalibration or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       oc_trip_reg <= 1'b0;
        else if (bus.recal)               oc_trip_reg <= 1'b0;
        else if (accept_run && |trip_hit) oc_trip_reg <= 1'b1;
    end
    assign bus.oc_trip = oc_trip_reg;
`else
    assign bus.oc_trip = 1'b0;
`endif

endmodule
